seg_display_ctrl: RTL and testbench
===================================

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6: number of seven-segment digits driven.
REQ-002 SHALL have parameter DATA_W, default 32: width of loaded value; multiple of 4; DATA_W/4 (NIB) >= NUM_DIGITS.
REQ-003 SHALL have parameter TICK_DIV, default 25000000: clk cycles per blink/scroll tick; >= 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port load_valid, input, 1 bit: load request.
REQ-007 SHALL have port load_data, input, DATA_W bits: value to display.
REQ-008 SHALL have port load_mode, input, 2 bits: 00 static, 01 blink, 10 scroll, 11 treated as static.
REQ-009 SHALL have port load_ready, output, 1 bit: load acceptance allowed.
REQ-010 SHALL have port clear, input, 1 bit: synchronous return to blank IDLE.
REQ-011 SHALL have port segs, output, NUM_DIGITS*7 bits: digit i in bits [7i+6:7i], active-low, bit6=g .. bit0=a; digit 0 rightmost.

Function
REQ-012 SHALL accept a load when load_valid && load_ready at a rising edge, registering load_data and load_mode together.
REQ-013 SHALL update segs on the edge that accepts a load, so the new value is visible one cycle later.
REQ-014 SHALL implement states IDLE (all digits blank), SHOW (static/blink) and SCROLL; accepted mode 10 -> SCROLL, any other -> SHOW.
REQ-015 SHALL encode nibbles in hex: 0 -> 1000000, 8 -> 0000000, A -> 0001000, F -> 0001110; blank = 1111111.
REQ-016 SHALL in static mode show nibble i of the value on digit i, i = 0..NUM_DIGITS-1.
REQ-017 SHALL run a tick counter 0..TICK_DIV-1 in SHOW and SCROLL, asserting an internal tick on wrap.
REQ-018 SHALL in blink mode toggle a phase bit per tick, phase starting ON; phase OFF blanks all digits.
REQ-019 SHALL in SCROLL show nibble (offset+i) mod NIB on digit i; offset starts 0 and increments by 1 per tick, wrapping NIB-1 -> 0.
REQ-020 SHALL deassert load_ready in SCROLL until offset wraps to 0; on that wrap return to SHOW static with the same value and reassert load_ready.
REQ-021 SHALL hold load_ready high in IDLE and SHOW.
REQ-022 SHALL, on any accepted load, clear the tick counter, set phase ON and offset 0, overriding a tick in the same cycle.
REQ-023 SHALL, on clear, enter IDLE, blank segs, zero counters and raise load_ready next cycle; clear has priority over a simultaneous load.
REQ-024 SHALL keep all outputs registered; no combinational path from inputs to segs or load_ready.

Reset
REQ-025 SHALL on rst force state IDLE, segs all 1 (blank), load_ready 1, value 0, mode static, tick counter 0, offset 0, phase ON.
REQ-026 SHALL abandon any SCROLL or blink in progress when rst asserts mid-operation; no load accepted while rst is high.

Configuration
REQ-027 SHALL compile leading-zero blanking when macro SEG_LZ_BLANK_EN is defined: in SHOW, digits above the highest non-zero displayed nibble blank; digit 0 always shown (value 0 shows single "0").
REQ-028 SHALL without SEG_LZ_BLANK_EN display all digits including leading zeros; SCROLL never blanks leading zeros in either build.

Verification
REQ-029 SHALL cover: rst high then low -> segs all 1, load_ready=1; load 0x0012_34AB static -> next cycle digits0..5 = B,A,4,3,2,1.
REQ-030 SHALL cover: TICK_DIV=4, load 0x00000008 mode 01 -> digit0 = 0000000 for 4 cycles, blank for 4 cycles, repeating.
REQ-031 SHALL cover: TICK_DIV=4, NUM_DIGITS=6, load 0x76543210 mode 10 -> load_ready=0, digit0 shows 0,1,..,7 every 4 cycles; after 32 cycles load_ready=1, static.
REQ-032 SHALL cover: load_valid held during SCROLL -> not accepted until load_ready returns; load and tick same cycle -> counter 0, phase ON.
REQ-033 SHALL cover: with SEG_LZ_BLANK_EN, load 0x00000A0 static -> digits 0,1 = 0,A, digits 2..5 blank; without it digits 2..5 = 0.
REQ-034 SHALL cover: rst asserted asynchronously mid-SCROLL -> segs blank and load_ready=1 immediately, before next clk edge.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: registered hex driver for NUM_DIGITS seven-segment digits
// with static, blink and one-shot scroll modes.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   load_valid  load request, taken when load_ready is high
//   load_data   DATA_W-bit value to display (nibble i -> digit i)
//   load_mode   00 static, 01 blink, 10 scroll, 11 static
//   load_ready  high in IDLE/SHOW, low while a scroll pass runs
//   clear       synchronous return to blank IDLE, beats a load
//   segs        digit i at [7i+6:7i], active-low, bit6=g .. bit0=a
//
// Optional build macro: SEG_LZ_BLANK_EN blanks leading zero digits in SHOW.
module seg_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_W     = 32,
    parameter int TICK_DIV   = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    input  logic [DATA_W-1:0]       load_data,
    input  logic [1:0]              load_mode,
    output logic                    load_ready,
    input  logic                    clear,
    output logic [NUM_DIGITS*7-1:0] segs
);

    localparam int NIB   = DATA_W / 4;
    localparam int SW    = NUM_DIGITS * 7;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OFF_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_SCROLL
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  value_q, value_d;
    logic               blink_q, blink_d;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [SW-1:0]      segs_q, segs_d;
    logic               ready_q, ready_d;

    logic               accept;
    logic               tick;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Segment image for a given (next) state; evaluated on *_d values so
    // the picture lands in segs_q on the same edge as the state change.
    function automatic logic [SW-1:0] render(
        input state_t            st,
        input logic [DATA_W-1:0] val,
        input logic              blk,
        input logic              ph,
        input logic [OFF_W-1:0]  off
    );
        logic [SW-1:0] r;
        logic [3:0]    nib;
        int            idx;
`ifdef SEG_LZ_BLANK_EN
        logic          lead;
`endif
        r = '1;
        if (st == ST_SCROLL) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                idx = int'(off) + i;
                if (idx >= NIB) idx = idx - NIB;
                nib = val[4*idx +: 4];
                r[7*i +: 7] = hex7(nib);
            end
        end else if (st == ST_SHOW && (!blk || ph)) begin
`ifdef SEG_LZ_BLANK_EN
            // Walk from the top digit; stay blank until the first
            // non-zero nibble, but digit 0 always shows.
            lead = 1'b1;
            for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
                nib = val[4*i +: 4];
                if (nib != 4'h0 || i == 0) lead = 1'b0;
                r[7*i +: 7] = lead ? 7'h7F : hex7(nib);
            end
`else
            for (int i = 0; i < NUM_DIGITS; i++) begin
                nib = val[4*i +: 4];
                r[7*i +: 7] = hex7(nib);
            end
`endif
        end
        return r;
    endfunction

    assign accept = load_valid && ready_q;
    assign tick   = (state_q != ST_IDLE) && (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        blink_d = blink_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        off_d   = off_q;

        if (clear) begin
            state_d = ST_IDLE;
            blink_d = 1'b0;
            phase_d = 1'b1;
            cnt_d   = '0;
            off_d   = '0;
        end else if (accept) begin
            // A load restarts timing even if a tick lands this cycle.
            value_d = load_data;
            blink_d = (load_mode == 2'b01);
            state_d = (load_mode == 2'b10) ? ST_SCROLL : ST_SHOW;
            phase_d = 1'b1;
            cnt_d   = '0;
            off_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                end
                ST_SHOW: begin
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                    if (tick && blink_q) phase_d = ~phase_q;
                end
                ST_SCROLL: begin
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                    if (tick) begin
                        if (off_q == OFF_MAX) begin
                            off_d   = '0;
                            state_d = ST_SHOW;
                            blink_d = 1'b0;
                            phase_d = 1'b1;
                        end else begin
                            off_d = off_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        ready_d = (state_d != ST_SCROLL);
        segs_d  = render(state_d, value_d, blink_d, phase_d, off_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            value_q <= '0;
            blink_q <= 1'b0;
            phase_q <= 1'b1;
            cnt_q   <= '0;
            off_q   <= '0;
            segs_q  <= '1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            segs_q  <= segs_d;
            ready_q <= ready_d;
        end
    end

    assign segs       = segs_q;
    assign load_ready = ready_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: scoreboard bench for seg_display_ctrl
// (TICK_DIV=4, six digits, 32-bit value).
module tb_seg_display_ctrl;

    localparam int ND = 6;
    localparam int DW = 32;
    localparam int TD = 4;
    localparam logic [41:0] BLANK = {42{1'b1}};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic [1:0]    load_mode = 2'b00;
    logic          clear = 1'b0;
    logic          load_ready;
    logic [41:0]   segs;

    int total = 0;
    int bad   = 0;

    string       tag_q[$];
    logic [42:0] exp_q[$];

    seg_display_ctrl #(
        .NUM_DIGITS(ND),
        .DATA_W    (DW),
        .TICK_DIV  (TD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_mode (load_mode),
        .load_ready(load_ready),
        .clear     (clear),
        .segs      (segs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [42:0] got,
                       input logic [42:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    function automatic logic [41:0] stat(input logic [31:0] v);
        logic [41:0] r;
        int hi;
        hi = 0;
        for (int i = 0; i < ND; i++)
            if (v[4*i +: 4] != 4'h0) hi = i;
        for (int i = 0; i < ND; i++) begin
            r[7*i +: 7] = enc(v[4*i +: 4]);
`ifdef SEG_LZ_BLANK_EN
            if (i > hi) r[7*i +: 7] = 7'h7F;
`endif
        end
        return r;
    endfunction

    function automatic logic [41:0] scr(input logic [31:0] v, input int off);
        logic [41:0] r;
        int idx;
        for (int i = 0; i < ND; i++) begin
            idx = (off + i) % 8;
            r[7*i +: 7] = enc(v[4*idx +: 4]);
        end
        return r;
    endfunction

    // Expectation pushed with the stimulus, checked just after the edge.
    task automatic drive(input logic v, input logic [31:0] d,
                         input logic [1:0] m, input logic c,
                         input logic [42:0] e, input string t);
        @(negedge clk);
        load_valid = v;
        load_data  = d;
        load_mode  = m;
        clear      = c;
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [42:0] e, input string t);
        drive(1'b0, 32'h0, 2'b00, 1'b0, e, t);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0)
            chk(tag_q.pop_front(), {load_ready, segs}, exp_q.pop_front());
    end

    initial begin
        logic [42:0] e;

        #1 rst = 1'b1;
        #2 chk("rst_async", {load_ready, segs}, {1'b1, BLANK});
        @(negedge clk);
        rst = 1'b0;
        idle({1'b1, BLANK}, "post_rst");
        idle({1'b1, BLANK}, "idle_blank");

        drive(1'b1, 32'h001234AB, 2'b00, 1'b0,
              {1'b1, stat(32'h001234AB)}, "static_load");
        for (int k = 0; k < 5; k++)
            idle({1'b1, stat(32'h001234AB)}, "static_hold");

        drive(1'b1, 32'h8, 2'b01, 1'b0, {1'b1, stat(32'h8)}, "blink_load");
        for (int k = 1; k < 12; k++) begin
            e = (((k / 4) % 2) == 0) ? {1'b1, stat(32'h8)} : {1'b1, BLANK};
            idle(e, "blink_run");
        end
        drive(1'b1, 32'h5, 2'b01, 1'b0, {1'b1, stat(32'h5)}, "tick_load");
        for (int j = 1; j < 8; j++) begin
            e = (j < 4) ? {1'b1, stat(32'h5)} : {1'b1, BLANK};
            idle(e, "tick_load_run");
        end

        drive(1'b1, 32'h76543210, 2'b10, 1'b0,
              {1'b0, scr(32'h76543210, 0)}, "scroll_load");
        for (int k = 1; k < 34; k++) begin
            if (k < 32)      e = {1'b0, scr(32'h76543210, k / 4)};
            else if (k == 32) e = {1'b1, stat(32'h76543210)};
            else             e = {1'b1, stat(32'h11111111)};
            drive(k >= 10, 32'h11111111, 2'b00, 1'b0, e, "scroll_run");
        end
        idle({1'b1, stat(32'h11111111)}, "post_scroll");

        drive(1'b1, 32'h000000A0, 2'b00, 1'b0,
              {1'b1, stat(32'h000000A0)}, "lz_a0");
        idle({1'b1, stat(32'h000000A0)}, "lz_a0_hold");
        drive(1'b1, 32'h0, 2'b00, 1'b0, {1'b1, stat(32'h0)}, "lz_zero");

        drive(1'b1, 32'h00ABCDEF, 2'b11, 1'b0,
              {1'b1, stat(32'h00ABCDEF)}, "mode3_load");
        for (int k = 0; k < 6; k++)
            idle({1'b1, stat(32'h00ABCDEF)}, "mode3_hold");

        drive(1'b1, 32'h12345678, 2'b10, 1'b1, {1'b1, BLANK}, "clear_pri");
        idle({1'b1, BLANK}, "clear_idle");
        idle({1'b1, BLANK}, "clear_idle");

        drive(1'b1, 32'h76543210, 2'b10, 1'b0,
              {1'b0, scr(32'h76543210, 0)}, "scroll2_load");
        for (int k = 1; k < 6; k++)
            idle({1'b0, scr(32'h76543210, k / 4)}, "scroll2_run");
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("rst_mid_scroll", {load_ready, segs}, {1'b1, BLANK});
        drive(1'b1, 32'h76543210, 2'b10, 1'b0, {1'b1, BLANK}, "rst_noload");
        @(negedge clk);
        rst        = 1'b0;
        load_valid = 1'b0;
        tag_q.push_back("rst_release");
        exp_q.push_back({1'b1, BLANK});
        idle({1'b1, BLANK}, "after_rst");
        drive(1'b1, 32'h000000A0, 2'b00, 1'b0,
              {1'b1, stat(32'h000000A0)}, "resume_load");
        idle({1'b1, stat(32'h000000A0)}, "resume_hold");

        repeat (3) @(posedge clk);
        #2 chk("drain", 43'(exp_q.size()), 43'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
